// File: rtl/opc_bus_pkg.sv
// Shared OPC bus constants and the loader frame state type.
// Imported by the memory responder and its byte-stream loader.
package opc_bus_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ZP_BASE   = 11'h000;
    localparam logic [ADDR_W-1:0] PROG_BASE = 11'h100;

    typedef enum logic [1:0] {
        IDLE,
        A_LO,
        CNT,
        DATA
    } ld_state_t;

endpackage

// File: rtl/opc_mem_loader.sv
// Byte-stream frame loader: ADDR_HI, ADDR_LO, COUNT, then COUNT data bytes.
// Holds the CPU in reset while a frame is in flight and emits a RAM write strobe.
module opc_mem_loader
    import opc_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    ld_state_t         state;
    logic [2:0]        addr_hi;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] cnt;
    logic              accept;

    assign accept  = ld_valid && ld_ready;
    assign wr_en   = accept && (state == DATA);
    assign wr_addr = ptr;
    assign wr_data = ld_data;

    // The pointer is 11 bits, so running off 0x7FF wraps naturally to 0x000.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_hi  <= '0;
            ptr      <= '0;
            cnt      <= '0;
            ld_ready <= 1'b0;
            cpu_hold <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_ready <= 1'b1;
            ld_done  <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        addr_hi  <= ld_data[2:0];
                        cpu_hold <= 1'b1;
                        state    <= A_LO;
                    end
                    A_LO: begin
                        ptr   <= {addr_hi, ld_data};
                        state <= CNT;
                    end
                    CNT: begin
                        cnt <= ld_data;
                        if (ld_data == '0) begin
                            state    <= IDLE;
                            cpu_hold <= 1'b0;
                            ld_done  <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == 8'd1) begin
                            state    <= IDLE;
                            cpu_hold <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/opc_mem_responder.sv
// Memory-side responder for the OPC CPU bus: page-zero and program RAM windows,
// combinational reads, and write arbitration between the CPU and the loader.
module opc_mem_responder
    import opc_bus_pkg::*;
#(
    parameter int ZP_WORDS   = 16,
    parameter int PROG_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rnw,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done
);

    logic [DATA_W-1:0] zp_ram   [ZP_WORDS];
    logic [DATA_W-1:0] prog_ram [PROG_WORDS];

    logic              ld_wr_en;
    logic [ADDR_W-1:0] ld_wr_addr;
    logic [DATA_W-1:0] ld_wr_data;
    logic              cpu_wr;

    assign cpu_wr = !bus_rnw && !cpu_hold;

    opc_mem_loader u_loader (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .ld_done  (ld_done),
        .wr_en    (ld_wr_en),
        .wr_addr  (ld_wr_addr),
        .wr_data  (ld_wr_data)
    );

    // Loader wins a same-byte collision; addresses matching no window are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ZP_WORDS; i++) zp_ram[i] <= '0;
            for (int i = 0; i < PROG_WORDS; i++) prog_ram[i] <= '0;
        end else begin
            for (int i = 0; i < ZP_WORDS; i++) begin
                if (ld_wr_en && ld_wr_addr == ZP_BASE + ADDR_W'(i))
                    zp_ram[i] <= ld_wr_data;
                else if (cpu_wr && bus_addr == ZP_BASE + ADDR_W'(i))
                    zp_ram[i] <= bus_wdata;
            end
            for (int i = 0; i < PROG_WORDS; i++) begin
                if (ld_wr_en && ld_wr_addr == PROG_BASE + ADDR_W'(i))
                    prog_ram[i] <= ld_wr_data;
                else if (cpu_wr && bus_addr == PROG_BASE + ADDR_W'(i))
                    prog_ram[i] <= bus_wdata;
            end
        end
    end

    // The CPU samples read data in the same cycle, so this path stays combinational.
    always_comb begin
        bus_rdata = '0;
        for (int i = 0; i < ZP_WORDS; i++)
            if (bus_addr == ZP_BASE + ADDR_W'(i)) bus_rdata = zp_ram[i];
        for (int i = 0; i < PROG_WORDS; i++)
            if (bus_addr == PROG_BASE + ADDR_W'(i)) bus_rdata = prog_ram[i];
    end

endmodule

// File: tb/tb_opc_mem_responder.sv
// Directed bench for opc_mem_responder; expected RAM contents are queued as frames
// are sent and drained through bus reads afterwards.
module tb_opc_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] bus_addr;
    logic        bus_rnw;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        cpu_hold;
    logic        ld_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    opc_mem_responder #(.ZP_WORDS(16), .PROG_WORDS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_rnw   (bus_rnw),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_hold  (cpu_hold),
        .ld_done   (ld_done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Loader byte presented mid-cycle; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = b;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
    endtask

    task automatic expect_byte(input logic [10:0] a, input logic [7:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    task automatic drain_scoreboard(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            bus_addr = e.addr;
            #2;
            check($sformatf("%s rd %h", tag, e.addr), bus_rdata, e.data);
        end
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_rnw   = 1'b0;
        @(posedge clk);
        #1;
        bus_rnw = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        bus_addr  = '0;
        bus_rnw   = 1'b1;
        bus_wdata = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("ready in reset", {7'd0, ld_ready}, 8'h00);
        check("hold in reset", {7'd0, cpu_hold}, 8'h00);
        check("done in reset", {7'd0, ld_done}, 8'h00);
        expect_byte(11'h000, 8'h00);
        expect_byte(11'h105, 8'h00);
        expect_byte(11'h7FF, 8'h00);
        drain_scoreboard("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready after reset", {7'd0, ld_ready}, 8'h01);

        // Frame 01,00,03,A9,3C,FF with a gap after ADDR_LO
        send_byte(8'h01);
        check("hold after ADDR_HI", {7'd0, cpu_hold}, 8'h01);
        send_byte(8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("hold during gap", {7'd0, cpu_hold}, 8'h01);
        send_byte(8'h03);
        send_byte(8'hA9);
        send_byte(8'h3C);
        check("hold before last", {7'd0, cpu_hold}, 8'h01);
        check("done before last", {7'd0, ld_done}, 8'h00);
        send_byte(8'hFF);
        check("done after last", {7'd0, ld_done}, 8'h01);
        check("hold after last", {7'd0, cpu_hold}, 8'h00);
        @(posedge clk);
        #1;
        check("done one cycle", {7'd0, ld_done}, 8'h00);
        expect_byte(11'h100, 8'hA9);
        expect_byte(11'h101, 8'h3C);
        expect_byte(11'h102, 8'hFF);
        expect_byte(11'h103, 8'h00);
        drain_scoreboard("frame1");

        // CPU writes: in-window and just past page zero
        cpu_write(11'h00F, 8'h55);
        check("cpu wr 00F", bus_rdata, 8'h55);
        cpu_write(11'h010, 8'h77);
        check("cpu wr 010 dropped", bus_rdata, 8'h00);

        // Wrapping frame, back-to-back bytes
        send_byte(8'h07);
        send_byte(8'hFF);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        check("wrap done", {7'd0, ld_done}, 8'h01);
        expect_byte(11'h7FF, 8'h00);
        expect_byte(11'h000, 8'h22);
        expect_byte(11'h00F, 8'h55);
        drain_scoreboard("wrap");

        // Empty frame
        send_byte(8'h00);
        send_byte(8'h00);
        check("empty hold", {7'd0, cpu_hold}, 8'h01);
        send_byte(8'h00);
        check("empty done", {7'd0, ld_done}, 8'h01);
        check("empty hold clr", {7'd0, cpu_hold}, 8'h00);
        @(posedge clk);
        #1;
        check("empty done clr", {7'd0, ld_done}, 8'h00);
        expect_byte(11'h000, 8'h22);
        expect_byte(11'h100, 8'hA9);
        drain_scoreboard("empty");

        // Reset in the middle of a 4-byte frame
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h04);
        send_byte(8'hD1);
        send_byte(8'hD2);
        rst = 1'b1;
        #1;
        check("hold async drop", {7'd0, cpu_hold}, 8'h00);
        check("ready in mid rst", {7'd0, ld_ready}, 8'h00);
        expect_byte(11'h104, 8'h00);
        expect_byte(11'h105, 8'h00);
        expect_byte(11'h100, 8'h00);
        expect_byte(11'h00F, 8'h00);
        expect_byte(11'h000, 8'h00);
        drain_scoreboard("midrst");
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h02);
        send_byte(8'hE1);
        send_byte(8'hE2);
        check("post rst done", {7'd0, ld_done}, 8'h01);
        expect_byte(11'h104, 8'hE1);
        expect_byte(11'h105, 8'hE2);
        expect_byte(11'h106, 8'h00);
        drain_scoreboard("postrst");

        // CPU writes while held, one colliding with a loader write
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        ld_valid  = 1'b1;
        ld_data   = 8'h5A;
        bus_addr  = 11'h101;
        bus_wdata = 8'hC3;
        bus_rnw   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        ld_data   = 8'h6B;
        bus_addr  = 11'h103;
        bus_wdata = 8'h99;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        bus_rnw  = 1'b1;
        check("held done", {7'd0, ld_done}, 8'h01);
        expect_byte(11'h101, 8'h5A);
        expect_byte(11'h102, 8'h6B);
        expect_byte(11'h103, 8'h00);
        drain_scoreboard("held");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
